load_use_stall_controller: RTL and testbench

Consumer-side counterpart of the load-use hazard detector. Takes the registered request flags (bubble, rs1/rs2 forward-from-WB) and turns them into pipeline actions: freezes PC and IF/ID, injects one NOP into ID/EX, then drives the WB-forwarding mux selects for the replayed instruction. Also arbitrates against branch flush and data-memory wait, and keeps a saturating stall-cycle counter. Sits in the control path between the hazard detect units and the pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/load_use_stall_controller_if.sv | 36 +++
 rtl/sat_counter.sv | 31 +++
 rtl/load_use_stall_controller.sv | 126 ++++++++++++
 tb/tb_load_use_stall_controller.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared control-path types and constants for the load-use stall controller
// and its neighbouring pipeline-control blocks.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REPLAY   = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  // addi x0, x0, 0 -- the canonical RISC-V NOP loaded into flushed stages.
  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam int          CNT_W_DEF = 32;

endpackage

// File: rtl/load_use_stall_controller_if.sv
// Hazard-request inputs and pipeline-action outputs of the load-use stall
// controller, bundled as one interface.
interface load_use_stall_controller_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             hz_bubble;
  logic             hz_fwd_rs1;
  logic             hz_fwd_rs2;
  logic             branch_flush;
  logic             mem_busy;
  logic             cnt_clr;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic             fwd_rs1_wb;
  logic             fwd_rs2_wb;
  logic [CNT_W-1:0] stall_count;
  logic             busy;

  // master: hazard units and pipeline side; slave: the controller itself.
  modport master (
    output hz_bubble, hz_fwd_rs1, hz_fwd_rs2, branch_flush, mem_busy, cnt_clr,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pipe_hold,
           fwd_rs1_wb, fwd_rs2_wb, stall_count, busy
  );

  modport slave (
    input  hz_bubble, hz_fwd_rs1, hz_fwd_rs2, branch_flush, mem_busy, cnt_clr,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pipe_hold,
           fwd_rs1_wb, fwd_rs2_wb, stall_count, busy
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and
// the value sticks at all-ones instead of wrapping.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign value = cnt_q;
endmodule

// File: rtl/load_use_stall_controller.sv
// Turns registered load-use hazard requests into freeze / bubble / forward
// actions, arbitrated against memory wait and branch flush.
module load_use_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  load_use_stall_controller_if.slave   bus
);
  // Reset asserts immediately but deasserts only after two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e state_q, state_d, ret_q, ret_d;
  logic   fwd_q1, fwd_q2, fwd_d1, fwd_d2;
  logic   pc_we, ifid_we, ifid_fl, idex_bub, hold, fwd1, fwd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      fwd_q1  <= 1'b0;
      fwd_q2  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fwd_q1  <= fwd_d1;
      fwd_q2  <= fwd_d2;
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    fwd_d1   = fwd_q1;
    fwd_d2   = fwd_q2;
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_bub = 1'b0;
    hold     = 1'b0;
    fwd1     = 1'b0;
    fwd2     = 1'b0;

    case (state_q)
      STALL: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_bub = 1'b1;
      end
      REPLAY: begin
        fwd1 = fwd_q1;
        fwd2 = fwd_q2;
      end
      MEM_WAIT: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        hold    = 1'b1;
      end
      default: ;
    endcase

    // A held pipeline must not see a bubble or a forward; the interrupted
    // state is parked in ret_q and replayed once memory is ready.
    if (bus.mem_busy) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      hold     = 1'b1;
      idex_bub = 1'b0;
      fwd1     = 1'b0;
      fwd2     = 1'b0;
      state_d  = MEM_WAIT;
      if (state_q != MEM_WAIT) ret_d = state_q;
    end else if (state_q == MEM_WAIT) begin
      state_d = ret_q;
    end else if (bus.branch_flush) begin
      // The PC must take the branch target even if a stall was pending.
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      ifid_fl  = 1'b1;
      idex_bub = 1'b1;
      state_d  = RUN;
      fwd_d1   = 1'b0;
      fwd_d2   = 1'b0;
    end else begin
      case (state_q)
        RUN, REPLAY: begin
          if (bus.hz_bubble) begin
            state_d = STALL;
            fwd_d1  = bus.hz_fwd_rs1;
            fwd_d2  = bus.hz_fwd_rs2;
          end else begin
            state_d = RUN;
          end
        end
        STALL:   state_d = REPLAY;
        default: state_d = RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_q == STALL) || (state_q == MEM_WAIT)),
    .clr   (bus.cnt_clr),
    .value (bus.stall_count)
  );

  assign bus.pc_write_en   = pc_we;
  assign bus.ifid_write_en = ifid_we;
  assign bus.ifid_flush    = ifid_fl;
  assign bus.idex_bubble   = idex_bub;
  assign bus.pipe_hold     = hold;
  assign bus.fwd_rs1_wb    = fwd1;
  assign bus.fwd_rs2_wb    = fwd2;
  assign bus.busy          = (state_q != RUN);
endmodule

// File: tb/tb_load_use_stall_controller.sv
// Directed-vector bench for load_use_stall_controller: each vector pushes its
// hand-computed per-cycle outputs into a scoreboard drained by a monitor.
module tb_load_use_stall_controller;
  import pipe_ctrl_pkg::*;

  localparam int W = 4;

  // Input bits: {hz_bubble, hz_fwd_rs1, hz_fwd_rs2, branch_flush, mem_busy, cnt_clr}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] BUB  = 6'b100000;
  localparam logic [5:0] R1   = 6'b010000;
  localparam logic [5:0] R2   = 6'b001000;
  localparam logic [5:0] FL   = 6'b000100;
  localparam logic [5:0] MB   = 6'b000010;
  localparam logic [5:0] CLR  = 6'b000001;

  // Output bits: {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, fwd1, fwd2, busy}
  localparam logic [7:0] O_RUN  = 8'b1100_0000;
  localparam logic [7:0] O_STL  = 8'b0001_0001;
  localparam logic [7:0] O_RP0  = 8'b1100_0001;
  localparam logic [7:0] O_RP1  = 8'b1100_0101;
  localparam logic [7:0] O_RP2  = 8'b1100_0011;
  localparam logic [7:0] O_FLR  = 8'b1111_0000;
  localparam logic [7:0] O_FLS  = 8'b1111_0001;
  localparam logic [7:0] O_HLDR = 8'b0000_1000;
  localparam logic [7:0] O_HLDB = 8'b0000_1001;

  typedef struct packed {
    logic [7:0] outs;
    int         cnt;   // -1: stall_count not checked this cycle
  } exp_t;

  logic  clk;
  logic  reset;
  exp_t  sb[$];
  string tag_q[$];
  int    tests;
  int    fails;
  exp_t  me;
  string mtag;
  logic [7:0] got;

  load_use_stall_controller_if #(.CNT_W(W)) bus ();

  load_use_stall_controller #(.CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] outs_now();
    return {bus.pc_write_en, bus.ifid_write_en, bus.ifid_flush, bus.idex_bubble,
            bus.pipe_hold, bus.fwd_rs1_wb, bus.fwd_rs2_wb, bus.busy};
  endfunction

  task automatic drive(input logic [5:0] in);
    {bus.hz_bubble, bus.hz_fwd_rs1, bus.hz_fwd_rs2,
     bus.branch_flush, bus.mem_busy, bus.cnt_clr} = in;
  endtask

  task automatic vec(input string tag, input logic [5:0] in, input logic [7:0] o, input int cnt);
    exp_t e;
    @(posedge clk);
    #1;
    drive(in);
    e.outs = o;
    e.cnt  = cnt;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      me   = sb.pop_front();
      mtag = tag_q.pop_front();
      got  = outs_now();
      tests++;
      if ((got !== me.outs) || ((me.cnt >= 0) && (bus.stall_count !== W'(me.cnt)))) begin
        fails++;
        $display("FAIL %s: outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                 mtag, got, bus.stall_count, me.outs, me.cnt);
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    drive(NONE);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    repeat (3) @(posedge clk);

    vec("idle",          NONE,         O_RUN, 0);
    vec("ld_rs1",        BUB|R1,       O_RUN, 0);
    vec("ld_rs1_stall",  NONE,         O_STL, 0);
    vec("ld_rs1_replay", NONE,         O_RP1, 1);
    vec("ld_rs1_run",    CLR,          O_RUN, 1);
    vec("b2b_ld1",       BUB|R2,       O_RUN, 0);
    vec("b2b_stall1",    NONE,         O_STL, 0);
    vec("b2b_replay1",   BUB|R1,       O_RP2, 1);
    vec("b2b_stall2",    NONE,         O_STL, 1);
    vec("b2b_replay2",   NONE,         O_RP1, 2);
    vec("b2b_run",       NONE,         O_RUN, 2);
    vec("noflag_ld",     BUB,          O_RUN, 2);
    vec("noflag_stall",  NONE,         O_STL, 2);
    vec("noflag_replay", NONE,         O_RP0, 3);
    vec("noflag_run",    NONE,         O_RUN, 3);
    vec("flush_bub",     BUB|R1|R2|FL, O_FLR, 3);
    vec("flush_next",    NONE,         O_RUN, 3);
    vec("flst_ld",       BUB|R1,       O_RUN, 3);
    vec("flst_stall",    FL,           O_FLS, 3);
    vec("flst_run",      NONE,         O_RUN, 4);
    vec("mw_clr",        CLR,          O_RUN, 4);
    vec("mw_ld",         BUB|R2,       O_RUN, 0);
    vec("mw_stall_busy", MB,           O_HLDB, 0);
    vec("mw_wait1",      MB,           O_HLDB, 1);
    vec("mw_wait2",      NONE,         O_HLDB, 2);
    vec("mw_stall",      NONE,         O_STL, 3);
    vec("mw_replay",     NONE,         O_RP2, 4);
    vec("mw_run",        NONE,         O_RUN, 4);
    vec("prio_all",      MB|FL|BUB,    O_HLDR, 4);
    vec("prio_wait",     NONE,         O_HLDB, 4);
    vec("prio_run",      NONE,         O_RUN, 5);
    vec("sat_clr",       CLR,          O_RUN, 5);
    vec("sat_enter",     MB,           O_HLDR, 0);
    for (int i = 0; i < 20; i++) vec("sat_fill", MB, O_HLDB, -1);
    vec("sat_top",       MB,           O_HLDB, 15);
    vec("sat_hold",      MB|CLR,       O_HLDB, 15);
    vec("sat_cleared",   NONE,         O_HLDB, 0);
    vec("sat_run",       NONE,         O_RUN, 1);

    // Asynchronous reset in the middle of a STALL cycle.
    @(posedge clk); #1 drive(BUB|R1);
    @(posedge clk); #1 drive(NONE);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (outs_now() !== O_RUN) begin
      fails++;
      $display("FAIL async_reset_outs: outs=%b, expected outs=%b", outs_now(), O_RUN);
    end
    tests++;
    if (bus.stall_count !== '0) begin
      fails++;
      $display("FAIL async_reset_cnt: cnt=%0d, expected cnt=0", bus.stall_count);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    vec("post_rst0",     NONE,         O_RUN, 0);
    vec("post_rst1",     NONE,         O_RUN, 0);
    vec("post_rst2",     NONE,         O_RUN, 0);
    vec("post_ld",       BUB|R1|R2,    O_RUN, 0);
    vec("post_stall",    NONE,         O_STL, 0);
    vec("post_replay",   NONE,         8'b1100_0111, 1);
    vec("post_run",      NONE,         O_RUN, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: pending=%0d, expected pending=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
